regfile_wb: RTL
===============

Name: regfile_wb

Overview:
- Register file that terminates the writeback interface: it consumes the writeback stage's data, destination and write-enable, and serves the two decode read ports.
- Contains a per-register pending-write scoreboard. Decode claims destinations at issue; writeback retires them.
- Produces a decode stall when a source operand still has an outstanding write.
- Sits inside the decode stage, between the writeback outputs and the decode/execute pipeline register.

Parameters:
- NREG, 32, number of architectural registers; r0 reads as zero.
- DW, 32, data width.
- AW, 5, register address width.
- CNTW, 2, scoreboard counter width per register; max outstanding writes = 2^CNTW-1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_data  in  DW  write data from writeback (ALU result, DMEM data or PC+8).
- wb_addr  in  AW  destination register from writeback (rt, rd or r31).
- wb_we  in  1  register write enable from writeback.
- rs_addr  in  AW  read port A address (insn[25:21]).
- rt_addr  in  AW  read port B address (insn[20:16]).
- rs_used  in  1  port A operand is consumed by the decoding instruction.
- rt_used  in  1  port B operand is consumed by the decoding instruction.
- claim_en  in  1  decode issues an instruction that will write claim_addr.
- claim_addr  in  AW  destination claimed at issue.
- rs_data  out  DW  port A read data.
- rt_data  out  DW  port B read data.
- stall  out  1  decode must hold; the instruction is not issued.
- sb_err  out  1  sticky scoreboard protocol error.

Behaviour:
- Reset (clock edge with reset=1): all registers = 0, all counters = 0, sb_err = 0. Reset wins over any simultaneous write or claim.
- Write: on a rising edge with wb_we=1 and wb_addr!=0, reg[wb_addr] <= wb_data. Writes to r0 are discarded.
- Read: rs_data and rt_data are combinational; 0 when the address is 0.
- Scoreboard counter per register, updated at the clock edge:
  - The claim increments the counter when claim_en=1, stall=0, claim_addr!=0.
  - A retire decrements it when wb_we=1 and wb_addr!=0.
  - A claim and a retire on the same register in the same cycle leave the counter unchanged.
  - A claim on a counter already at max is dropped and sets sb_err.
  - A retire on a counter at 0 leaves it at 0 and sets sb_err.
  - sb_err clears only on reset.
- Pending(x) = counter[x]!=0, with x != 0.
- stall = (rs_used & pending(rs_addr)) | (rt_used & pending(rt_addr)). Combinational, no latency.
- A stalled cycle performs no claim, even when claim_en=1.
- Counters never wrap.
- The scoreboard does not self-clear; pipeline flushes are not supported by this block.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- When defined:
  - A read whose address equals wb_addr, with wb_we=1 and the address non-zero, returns wb_data in the same cycle.
  - pending(x) excludes the final in-flight write: a register with counter=1 that is being retired this cycle is not pending.
  - Dependent instructions therefore issue one cycle earlier.
- When undefined:
  - Reads return only the stored value.
  - Any counter!=0 stalls.
  - A retiring register becomes readable on the next cycle.

Test Plan:
- Reset then read all 32 addresses -> every read returns 0x00000000, stall=0, sb_err=0.
- Write r5=0xDEADBEEF (wb_we=1), read rs_addr=5 next cycle -> rs_data=0xDEADBEEF. Write r0=0x1234 -> r0 still reads 0.
- Claim r8, then rs_addr=8 with rs_used=1 -> stall=1. Retire r8 with 0x55 -> stall=0 the next cycle (without bypass) and rs_data=0x55. With bypass, stall=0 and rs_data=0x55 in the retire cycle itself.
- Claim r31 three times, then a fourth claim -> counter holds 3 and sb_err=1. Three retires -> stall on r31 drops after the third.
- Claim and retire r9 in the same cycle while its counter=1 -> counter stays 1 and stall persists. With rt_used=0 and rt_addr=9 -> stall=0.
- Assert reset mid-operation while counter[4]=2 and wb_we=1 -> next cycle all counters 0, r4 reads 0, sb_err=0.

Source files
------------

// File: rtl/regfile_wb.sv
// Writeback-terminating register file with per-register pending-write scoreboard.
// Optional same-cycle writeback bypass enabled by defining REGFILE_BYPASS_EN.

module regfile_sb_cnt #(
    parameter int CNTW = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            inc,
    input  logic            dec,
    output logic [CNTW-1:0] cnt,
    output logic            err
);
    localparam logic [CNTW-1:0] MAX = '1;

    // A simultaneous claim and retire cancel out and are never an error.
    always_comb begin
        err = (inc & ~dec & (cnt == MAX)) | (dec & ~inc & (cnt == '0));
    end

    always_ff @(posedge clock) begin
        if (reset)
            cnt <= '0;
        else if (inc & ~dec & (cnt != MAX))
            cnt <= cnt + CNTW'(1);
        else if (dec & ~inc & (cnt != '0))
            cnt <= cnt - CNTW'(1);
    end
endmodule

module regfile_wb #(
    parameter int NREG = 32,
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int CNTW = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] wb_data,
    input  logic [AW-1:0] wb_addr,
    input  logic          wb_we,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    input  logic          rs_used,
    input  logic          rt_used,
    input  logic          claim_en,
    input  logic [AW-1:0] claim_addr,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    output logic          stall,
    output logic          sb_err
);
    logic [DW-1:0]             regs [1:NREG-1];
    logic [NREG-1:1]           inc, dec, err_vec;
    logic [NREG-1:1][CNTW-1:0] cnt;
    logic [NREG-1:0]           pend;
    logic                      retire, claim_ok;

    assign retire = wb_we & (wb_addr != '0);

    always_comb begin
        pend = '0;
        for (int g = 1; g < NREG; g++) begin
`ifdef REGFILE_BYPASS_EN
            // The last outstanding write landing now is forwarded, so it does not block.
            pend[g] = (cnt[g] != '0) & ~((cnt[g] == CNTW'(1)) & dec[g]);
`else
            pend[g] = (cnt[g] != '0);
`endif
        end
    end

    assign stall    = (rs_used & pend[rs_addr]) | (rt_used & pend[rt_addr]);
    assign claim_ok = claim_en & ~stall & (claim_addr != '0);

    always_comb begin
        inc = '0;
        dec = '0;
        for (int g = 1; g < NREG; g++) begin
            inc[g] = claim_ok & (claim_addr == AW'(g));
            dec[g] = retire & (wb_addr == AW'(g));
        end
    end

    for (genvar g = 1; g < NREG; g++) begin : g_sb
        regfile_sb_cnt #(.CNTW(CNTW)) u_cnt (
            .clock (clock),
            .reset (reset),
            .inc   (inc[g]),
            .dec   (dec[g]),
            .cnt   (cnt[g]),
            .err   (err_vec[g])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int g = 1; g < NREG; g++)
                regs[g] <= '0;
        end else if (retire) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            sb_err <= 1'b0;
        else if (|err_vec)
            sb_err <= 1'b1;
    end

    always_comb begin
        rs_data = (rs_addr == '0) ? '0 : regs[rs_addr];
        rt_data = (rt_addr == '0) ? '0 : regs[rt_addr];
`ifdef REGFILE_BYPASS_EN
        if (retire && (rs_addr == wb_addr)) rs_data = wb_data;
        if (retire && (rt_addr == wb_addr)) rt_data = wb_data;
`endif
    end
endmodule
